// File: rtl/rt_fixed_pkg.sv
// Shared fixed-point helpers for the ray traversal datapath.
package rt_fixed_pkg;

   localparam int unsigned W_DEF    = 32;
   localparam int unsigned FRAC_DEF = 16;
   localparam int unsigned ID_W_DEF = 8;

   // Widest data word the helpers support; callers sign-extend into and truncate out of these.
   localparam int unsigned MAX_W = 64;
   localparam int unsigned MAX_P = 2 * MAX_W + 1;

   // Arithmetic shift right by frac (floor), then clamp to the signed w-bit range.
   function automatic logic signed [MAX_W-1:0] sat_shift(input logic signed [MAX_P-1:0] prod,
                                                         input int unsigned w,
                                                         input int unsigned frac);
      logic signed [MAX_P-1:0] sh;
      logic signed [MAX_P-1:0] hi;
      logic signed [MAX_P-1:0] lo;
      sh = prod >>> frac;
      hi = (MAX_P'(1) <<< (w - 1)) - MAX_P'(1);
      lo = -hi - MAX_P'(1);
      if (sh > hi)
         sat_shift = MAX_W'(hi);
      else if (sh < lo)
         sat_shift = MAX_W'(lo);
      else
         sat_shift = MAX_W'(sh);
   endfunction

   function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                    input logic signed [MAX_W-1:0] b);
      smax = (a > b) ? a : b;
   endfunction

   function automatic logic signed [MAX_W-1:0] smin(input logic signed [MAX_W-1:0] a,
                                                    input logic signed [MAX_W-1:0] b);
      smin = (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/slab_axis.sv
// One slab axis: near/far select, subtract origin (S1), scale by inverse direction and saturate (S2).
module slab_axis
   import rt_fixed_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned FRAC = FRAC_DEF
) (
   input  logic         clk,
   input  logic         en1,
   input  logic         en2,
   input  logic         dir_neg,
   input  logic [W-1:0] bmin,
   input  logic [W-1:0] bmax,
   input  logic [W-1:0] org,
   input  logic [W-1:0] inv_dir,
   output logic [W-1:0] t_near,
   output logic [W-1:0] t_far
);

   localparam int unsigned DW = W + 1;
   localparam int unsigned PW = 2 * W + 1;

   logic signed [W-1:0]  near_c;
   logic signed [W-1:0]  far_c;
   logic signed [W-1:0]  org_s;
   logic signed [DW-1:0] d_near;
   logic signed [DW-1:0] d_far;
   logic signed [W-1:0]  inv_q;
   logic signed [PW-1:0] p_near_c;
   logic signed [PW-1:0] p_far_c;

   // Pick entry/exit planes from the direction sign.
   always_comb begin
      near_c = dir_neg ? signed'(bmax) : signed'(bmin);
      far_c  = dir_neg ? signed'(bmin) : signed'(bmax);
      org_s  = signed'(org);
   end

   // S1: plane distances at one extra bit so the subtraction cannot wrap.
   always_ff @(posedge clk) begin
      if (en1) begin
         d_near <= DW'(near_c) - DW'(org_s);
         d_far  <= DW'(far_c) - DW'(org_s);
         inv_q  <= signed'(inv_dir);
      end
   end

   // Full-precision products of the registered distances.
   always_comb begin
      p_near_c = PW'(d_near) * PW'(inv_q);
      p_far_c  = PW'(d_far) * PW'(inv_q);
   end

   // S2: rescale to the Q format and clamp.
   always_ff @(posedge clk) begin
      if (en2) begin
         t_near <= W'(sat_shift(MAX_P'(p_near_c), W, FRAC));
         t_far  <= W'(sat_shift(MAX_P'(p_far_c), W, FRAC));
      end
   end

endmodule

// File: rtl/ray_box_slab_pipe.sv
// Four-stage streaming ray/AABB slab intersector with valid/ready back-pressure.
module ray_box_slab_pipe
   import rt_fixed_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned FRAC = FRAC_DEF,
   parameter int unsigned ID_W = ID_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ID_W-1:0] in_id,
   input  logic [W-1:0]    in_min_t,
   input  logic [W-1:0]    in_max_t,
   input  logic [3*W-1:0]  in_bmin,
   input  logic [3*W-1:0]  in_bmax,
   input  logic [3*W-1:0]  in_org,
   input  logic [3*W-1:0]  in_inv_dir,
   input  logic [2:0]      in_dir_neg,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ID_W-1:0] out_id,
   output logic [W-1:0]    out_tmin,
   output logic [W-1:0]    out_tmax,
   output logic            out_hit
);

   logic v1, v2, v3;
   logic ld1, ld2, ld3, ld4;
   logic en1, en2, en3;

   logic [ID_W-1:0] id1, id2, id3;
   logic [W-1:0]    mn1, mx1, mn2, mx2;
   logic signed [W-1:0] tmin3, tmax3;

   logic [2:0][W-1:0] tn;
   logic [2:0][W-1:0] tf;

   logic signed [MAX_W-1:0] lo_c;
   logic signed [MAX_W-1:0] hi_c;

   // Stage load enables: a stage loads when empty or when its successor moves on.
   always_comb begin
      ld4      = !out_valid || out_ready;
      ld3      = !v3 || ld4;
      ld2      = !v2 || ld3;
      ld1      = !v1 || ld2;
      in_ready = ld1;
      en1      = ld1 && in_valid;
      en2      = ld2 && v1;
      en3      = ld3 && v2;
   end

   // Stage occupancy; in-flight work is dropped on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (ld1) v1 <= in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
         if (ld4) out_valid <= v3;
      end
   end

   for (genvar a = 0; a < 3; a++) begin : g_axis
      slab_axis #(.W(W), .FRAC(FRAC)) u_axis (
         .clk     (clk),
         .en1     (en1),
         .en2     (en2),
         .dir_neg (in_dir_neg[a]),
         .bmin    (in_bmin[a*W +: W]),
         .bmax    (in_bmax[a*W +: W]),
         .org     (in_org[a*W +: W]),
         .inv_dir (in_inv_dir[a*W +: W]),
         .t_near  (tn[a]),
         .t_far   (tf[a])
      );
   end

   // Sideband travelling alongside the S1/S2 slab data.
   always_ff @(posedge clk) begin
      if (en1) begin
         id1 <= in_id;
         mn1 <= in_min_t;
         mx1 <= in_max_t;
      end
      if (en2) begin
         id2 <= id1;
         mn2 <= mn1;
         mx2 <= mx1;
      end
   end

   // Interval reduction across the three axes and the ray bounds.
   always_comb begin
      lo_c = MAX_W'(signed'(mn2));
      hi_c = MAX_W'(signed'(mx2));
      for (int a = 0; a < 3; a++) begin
         lo_c = smax(lo_c, MAX_W'(signed'(tn[a])));
         hi_c = smin(hi_c, MAX_W'(signed'(tf[a])));
      end
   end

   // S3: reduced interval.
   always_ff @(posedge clk) begin
      if (en3) begin
         id3   <= id2;
         tmin3 <= W'(lo_c);
         tmax3 <= W'(hi_c);
      end
   end

   // S4: output register with hit; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_id   <= '0;
         out_tmin <= '0;
         out_tmax <= '0;
         out_hit  <= 1'b0;
      end else if (ld4 && v3) begin
         out_id   <= id3;
         out_tmin <= tmin3;
         out_tmax <= tmax3;
         out_hit  <= (tmin3 <= tmax3);
      end
   end

endmodule

// File: tb/tb_ray_box_slab_pipe.sv
// Bench for ray_box_slab_pipe: directed table, random stream against a reference model, stall and reset sequences.
module tb_ray_box_slab_pipe;

   localparam int W    = 32;
   localparam int ID_W = 8;
   localparam logic [31:0] ONE = 32'h0001_0000;
   localparam logic [31:0] M2  = 32'hFFFE_0000;   // -2.0
   localparam logic [31:0] M4  = 32'hFFFC_0000;   // -4.0
   localparam logic [31:0] HUN = 32'd100 << 16;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] min_t;
      logic [31:0] max_t;
      logic [95:0] bmin;
      logic [95:0] bmax;
      logic [95:0] org;
      logic [95:0] inv;
      logic [2:0]  neg;
   } query_t;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] tmin;
      logic [31:0] tmax;
      logic        hit;
   } exp_t;

   typedef struct packed {
      exp_t        e;
      logic [31:0] cyc;
   } pend_t;

   typedef struct {
      string  name;
      query_t q;
      exp_t   e;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [ID_W-1:0] in_id;
   logic [W-1:0]    in_min_t, in_max_t;
   logic [3*W-1:0]  in_bmin, in_bmax, in_org, in_inv_dir;
   logic [2:0]      in_dir_neg;
   logic            out_valid;
   logic            out_ready;
   logic [ID_W-1:0] out_id;
   logic [W-1:0]    out_tmin, out_tmax;
   logic            out_hit;

   ray_box_slab_pipe #(.W(W), .FRAC(16), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_id      (in_id),
      .in_min_t   (in_min_t),
      .in_max_t   (in_max_t),
      .in_bmin    (in_bmin),
      .in_bmax    (in_bmax),
      .in_org     (in_org),
      .in_inv_dir (in_inv_dir),
      .in_dir_neg (in_dir_neg),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_tmin   (out_tmin),
      .out_tmax   (out_tmax),
      .out_hit    (out_hit)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          outs     = 0;
   bit          lat_on   = 1'b0;
   pend_t       sb[$];
   pend_t       mon_p;
   exp_t        cur_exp;
   bit          stall_prev = 1'b0;
   logic [72:0] snap;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return {z, y, x};
   endfunction

   // Reference t: exact product, floor division by 2^16, clamp to the 32-bit signed range.
   function automatic longint fx(input longint d, input longint inv);
      logic signed [127:0] p;
      logic signed [127:0] q;
      p = 128'(d) * 128'(inv);
      q = p / 128'sd65536;
      if (p < 0 && (p % 128'sd65536) != 0) q = q - 128'sd1;
      if (q > 128'sd2147483647) return 64'sd2147483647;
      if (q < -128'sd2147483648) return -64'sd2147483648;
      return longint'(q);
   endfunction

   function automatic exp_t model(input query_t q);
      longint lo, hi, bmn, bmx, o, inv, nr, fr, tn, tf;
      exp_t   e;
      lo = longint'(signed'(q.min_t));
      hi = longint'(signed'(q.max_t));
      for (int a = 0; a < 3; a++) begin
         bmn = longint'(signed'(q.bmin[a*32 +: 32]));
         bmx = longint'(signed'(q.bmax[a*32 +: 32]));
         o   = longint'(signed'(q.org[a*32 +: 32]));
         inv = longint'(signed'(q.inv[a*32 +: 32]));
         nr  = q.neg[a] ? bmx : bmn;
         fr  = q.neg[a] ? bmn : bmx;
         tn  = fx(nr - o, inv);
         tf  = fx(fr - o, inv);
         if (tn > lo) lo = tn;
         if (tf < hi) hi = tf;
      end
      e.id   = q.id;
      e.tmin = 32'(lo);
      e.tmax = 32'(hi);
      e.hit  = (lo <= hi);
      return e;
   endfunction

   function automatic query_t mkq(input logic [7:0] id, input logic [95:0] org, input logic [95:0] inv,
                                  input logic [2:0] neg, input logic [31:0] mn, input logic [31:0] mx);
      query_t q;
      q.id    = id;
      q.min_t = mn;
      q.max_t = mx;
      q.bmin  = '0;
      q.bmax  = v3(4 * ONE, 4 * ONE, 4 * ONE);
      q.org   = org;
      q.inv   = inv;
      q.neg   = neg;
      return q;
   endfunction

   function automatic logic [31:0] small_fx();
      return 32'(int'($urandom_range(0, 32 * 65536)) - 16 * 65536);
   endfunction

   function automatic query_t rand_query();
      query_t q;
      for (int a = 0; a < 3; a++) begin
         q.bmin[a*32 +: 32] = small_fx();
         q.bmax[a*32 +: 32] = small_fx();
         q.org[a*32 +: 32]  = small_fx();
         q.inv[a*32 +: 32]  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'(signed'(small_fx()) >>> 2);
      end
      q.neg   = 3'($urandom);
      q.id    = 8'($urandom);
      q.min_t = 32'($urandom_range(0, 4 * 65536));
      q.max_t = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom_range(0, 64 * 65536));
      return q;
   endfunction

   task automatic drive(input query_t q, input exp_t e);
      in_id      = q.id;
      in_min_t   = q.min_t;
      in_max_t   = q.max_t;
      in_bmin    = q.bmin;
      in_bmax    = q.bmax;
      in_org     = q.org;
      in_inv_dir = q.inv;
      in_dir_neg = q.neg;
      cur_exp    = e;
   endtask

   task automatic send(input query_t q, input exp_t e);
      int n;
      drive(q, e);
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 128'(sb.size()), 128'(0));
   endtask

   // Scoreboard: each output handshake retires the oldest accepted query.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sb.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_hold_valid", 128'(out_valid), 128'(1));
            chk("stall_hold_data", 128'({out_id, out_tmin, out_tmax, out_hit}), 128'(snap));
         end
         if (out_valid && out_ready) begin
            outs++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_output: id 0x%0h with nothing pending", out_id);
            end else begin
               mon_p = sb.pop_front();
               chk("out_id", 128'(out_id), 128'(mon_p.e.id));
               chk("out_tmin", 128'(out_tmin), 128'(mon_p.e.tmin));
               chk("out_tmax", 128'(out_tmax), 128'(mon_p.e.tmax));
               chk("out_hit", 128'(out_hit), 128'(mon_p.e.hit));
               if (lat_on) chk("latency", 128'(32'(cyc) - mon_p.cyc), 128'(4));
            end
         end
         if (in_valid && in_ready) sb.push_back('{e: cur_exp, cyc: 32'(cyc)});
         stall_prev = out_valid && !out_ready;
         snap       = {out_id, out_tmin, out_tmax, out_hit};
      end
   end

   vec_t   tbl[7];
   query_t bpq[6];
   query_t rq;
   exp_t   re;
   bit     need_new;
   int     acc;
   int     outs0;

   initial begin
      tbl[0] = '{"hit_basic",   mkq(8'd5,  v3(M2, ONE, ONE),          v3(ONE, ONE, ONE), 3'b000, 0, HUN),
                 '{8'd5,  32'h0002_0000, 32'h0003_0000, 1'b1}};
      tbl[1] = '{"miss_y",      mkq(8'd6,  v3(M2, 5 * ONE, ONE),      v3(ONE, ONE, ONE), 3'b000, 0, HUN),
                 '{8'd6,  32'h0002_0000, 32'hFFFF_0000, 1'b0}};
      tbl[2] = '{"neg_dir_x",   mkq(8'd7,  v3(6 * ONE, ONE, ONE),     v3(32'hFFFF_0000, ONE, ONE), 3'b001, 0, HUN),
                 '{8'd7,  32'h0002_0000, 32'h0003_0000, 1'b1}};
      tbl[3] = '{"saturate_x",  mkq(8'd8,  v3(M4, ONE, ONE),          v3(32'h7FFF_FFFF, ONE, ONE), 3'b000, 0, HUN),
                 '{8'd8,  32'h7FFF_FFFF, 32'h0003_0000, 1'b0}};
      tbl[4] = '{"min_t_clamp", mkq(8'd9,  v3(M2, ONE, ONE),          v3(ONE, ONE, ONE), 3'b000, 32'h0002_8000, HUN),
                 '{8'd9,  32'h0002_8000, 32'h0003_0000, 1'b1}};
      tbl[5] = '{"max_t_clamp", mkq(8'd10, v3(M2, ONE, ONE),          v3(ONE, ONE, ONE), 3'b000, 0, 32'h0002_8000),
                 '{8'd10, 32'h0002_0000, 32'h0002_8000, 1'b1}};
      tbl[6] = '{"floor_neg",   mkq(8'd11, v3(M2, 32'h0004_0001, ONE), v3(ONE, 32'h0000_8000, ONE), 3'b000, 0, HUN),
                 '{8'd11, 32'h0002_0000, 32'hFFFF_FFFF, 1'b0}};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(tbl[0].q, tbl[0].e);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_outputs", 128'({out_id, out_tmin, out_tmax, out_hit}), 128'(0));
      rst_n = 1'b1;
      #1 chk("reset_in_ready", 128'(in_ready), 128'(1));

      // Directed table, back-to-back, consumer always ready.
      lat_on = 1'b1;
      for (int i = 0; i < 7; i++) send(tbl[i].q, tbl[i].e);
      wait_drain(40);

      // Random stream with random source gaps and consumer stalls.
      lat_on   = 1'b0;
      need_new = 1'b1;
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         if (need_new) begin
            rq = rand_query();
            re = model(rq);
            drive(rq, re);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         need_new = !(in_valid && !in_ready);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain(100);

      // Full stall: only four queries fit, then in order on release.
      for (int i = 0; i < 6; i++) begin
         bpq[i]    = rand_query();
         bpq[i].id = 8'(i);
      end
      acc   = 0;
      outs0 = outs;
      for (int i = 0; i < 60 && !(acc == 6 && sb.size() == 0); i++) begin
         @(posedge clk);
         #1;
         if (acc < 6) begin
            drive(bpq[acc], model(bpq[acc]));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (i >= 12);
         @(negedge clk);
         if (i == 11) begin
            chk("bp_accepted", 128'(acc), 128'(4));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_id", 128'(out_id), 128'(0));
         end
         if (in_valid && in_ready) acc++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_accepted_total", 128'(acc), 128'(6));
      chk("bp_outputs", 128'(outs - outs0), 128'(6));

      // Reset with three queries in flight.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rq    = rand_query();
         rq.id = 8'(8'h40 + 8'(i));
         send(rq, model(rq));
      end
      @(posedge clk);
      #1 chk("pre_reset_valid", 128'(out_valid), 128'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_outputs", 128'({out_id, out_tmin, out_tmax, out_hit}), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("midrst_in_ready", 128'(in_ready), 128'(1));
      outs0  = outs;
      lat_on = 1'b1;
      send(tbl[0].q, tbl[0].e);
      repeat (12) @(negedge clk);
      chk("post_rst_outputs", 128'(outs - outs0), 128'(1));
      chk("post_rst_pending", 128'(sb.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
